// File: rtl/run_detector_if.sv
// Sample/control inputs and run-status outputs of run_detector.
// master drives samples; slave is the detector.
interface run_detector_if #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int CW = $clog2(RUN_LEN + 1);

  logic             clr;
  logic             en;
  logic             w;
  logic [1:0]       mode;
  logic             z;
  logic             run_val;
  logic [CW-1:0]    run_cnt;
  logic [CNT_W-1:0] hits;

  modport master (
    output clr, en, w, mode,
    input  z, run_val, run_cnt, hits
  );

  modport slave (
    input  clr, en, w, mode,
    output z, run_val, run_cnt, hits
  );
endinterface

// File: rtl/run_detector.sv
// Detects RUN_LEN equal samples in a row on w.
// Polarity by mode, overlap/restart counting, saturating hits.
module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         reset,
  run_detector_if.slave bus
);
  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LEN   = CW'(RUN_LEN);
  localparam logic [CW-1:0] LENM1 = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CNT_W-1:0] HMAX = '1;
  localparam logic [CNT_W-1:0] HONE = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_st;
  logic             r_val;
  logic [CW-1:0]    r_cnt;
  logic             r_z;
  logic [CNT_W-1:0] r_hits;

  state_t           w_nst;
  logic             w_nval;
  logic [CW-1:0]    w_ncnt;
  logic             w_inc;
  logic             w_match;
  logic             w_hit;

  function automatic logic f_match(
    input logic [1:0] m,
    input logic       v
  );
    case (m)
      2'b01:   return v;
      2'b10:   return !v;
      default: return 1'b1;
    endcase
  endfunction

  // Next run state from clr/en/w and the current run.
  always_comb begin
    w_nst  = r_st;
    w_nval = r_val;
    w_ncnt = r_cnt;
    w_inc  = 1'b0;
    if (bus.clr) begin
      w_nst  = IDLE;
      w_nval = 1'b0;
      w_ncnt = '0;
    end else if (bus.en) begin
      if (r_st == IDLE) begin
        w_nst  = RUN;
        w_nval = bus.w;
        w_ncnt = ONE;
      end else if (bus.w != r_val) begin
        w_nval = bus.w;
        w_ncnt = ONE;
      end else if (r_cnt < LEN) begin
        w_ncnt = r_cnt + ONE;
        w_inc  = 1'b1;
      end else if (OVERLAP == 0) begin
        w_ncnt = ONE;
      end
    end
  end

  // Polarity match on the next run value; a hit is a fresh reach of RUN_LEN.
  always_comb begin
    w_match = f_match(bus.mode, w_nval);
    w_hit   = w_inc && (r_cnt == LENM1) && w_match;
  end

  // Run registers, Moore flag and saturating hit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st   <= IDLE;
      r_val  <= 1'b0;
      r_cnt  <= '0;
      r_z    <= 1'b0;
      r_hits <= '0;
    end else begin
      r_st  <= w_nst;
      r_val <= w_nval;
      r_cnt <= w_ncnt;
      r_z   <= (w_nst == RUN) && (w_ncnt == LEN) && w_match;
      if (bus.clr)
        r_hits <= '0;
      else if (w_hit && (r_hits != HMAX))
        r_hits <= r_hits + HONE;
    end
  end

  assign bus.z       = r_z;
  assign bus.run_val = r_val;
  assign bus.run_cnt = r_cnt;
  assign bus.hits    = r_hits;
endmodule
